gpr_wb_sched: RTL and testbench

Write-port scheduler and pending-register scoreboard for the 32x32 general-purpose register file. It shares the register file's single write port between the in-order pipeline writeback stage and an out-of-band long-latency result return (multiply/divide unit, load-miss refill). Because the long-latency result is buffered, the file's write port is never driven twice in one cycle. It also drives the ID-stage stall for RAW and WAW hazards against registers whose long-latency result has not yet landed.

---
 rtl/gpr_wb_sched_if.sv | 41 ++++
 rtl/gpr_wb_sched.sv | 99 +++++++++
 tb/tb_gpr_wb_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_sched_if.sv
// Bundle of signals between the GPR write-port scheduler and its neighbours:
// pipeline writeback, long-latency result return, ID hazard check and the register file port.
interface gpr_wb_sched_if;
    logic        pipe_regwr;
    logic [4:0]  pipe_regdst_addr;
    logic [31:0] pipe_data;
    logic        pipe_hold;

    logic        lng_issue;
    logic [4:0]  lng_issue_addr;
    logic        lng_valid;
    logic [4:0]  lng_addr;
    logic [31:0] lng_data;
    logic        lng_ready;

    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic        id_rd_valid;
    logic        id_stall;

    logic        wr_regwr;
    logic [4:0]  wr_regdst_addr;
    logic [31:0] wr_data;

    modport master (
        output pipe_regwr, pipe_regdst_addr, pipe_data,
        output lng_issue, lng_issue_addr, lng_valid, lng_addr, lng_data,
        output id_rs_addr, id_rt_addr, id_rd_addr, id_rd_valid,
        input  pipe_hold, lng_ready, id_stall,
        input  wr_regwr, wr_regdst_addr, wr_data
    );

    modport slave (
        input  pipe_regwr, pipe_regdst_addr, pipe_data,
        input  lng_issue, lng_issue_addr, lng_valid, lng_addr, lng_data,
        input  id_rs_addr, id_rt_addr, id_rd_addr, id_rd_valid,
        output pipe_hold, lng_ready, id_stall,
        output wr_regwr, wr_regdst_addr, wr_data
    );
endinterface

// File: rtl/gpr_wb_sched.sv
// Shares the GPR write port between pipeline writeback and a one-entry long-result buffer,
// and tracks pending long-latency destinations for ID stalls. Define GPR_WB_STARVE_EN for the starvation guard.
module gpr_wb_sched #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    gpr_wb_sched_if.slave  bus
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starveMaxRange
        $error("gpr_wb_sched: STARVE_MAX must be within 1..15");
    end

    logic [31:0] r_pending;
    logic        r_bufValid;
    logic [4:0]  r_bufAddr;
    logic [31:0] r_bufData;

    logic        w_portFree;
    logic        w_drain;
    logic        w_forceDrain;
    logic        w_lngReady;
    logic        w_accept;
    logic        w_pipeWrite;
    logic [31:0] w_pendingNext;

    assign w_portFree  = ~bus.pipe_regwr | (bus.pipe_regdst_addr == 5'd0);
    assign w_pipeWrite = bus.pipe_regwr & (bus.pipe_regdst_addr != 5'd0);
    assign w_drain     = r_bufValid & (w_portFree | w_forceDrain);
    assign w_lngReady  = ~r_bufValid & ~rst;
    assign w_accept    = bus.lng_valid & w_lngReady;

`ifdef GPR_WB_STARVE_EN
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] r_starveCnt;

    assign w_forceDrain = r_bufValid & ~w_portFree & (r_starveCnt == STARVE_LIMIT);

    // Counts consecutive cycles the buffered result lost the port; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= 4'd0;
        end else if (!r_bufValid || w_drain) begin
            r_starveCnt <= 4'd0;
        end else if (r_starveCnt != STARVE_LIMIT) begin
            r_starveCnt <= r_starveCnt + 4'd1;
        end
    end
`else
    assign w_forceDrain = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bufValid <= 1'b0;
            r_bufAddr  <= 5'd0;
            r_bufData  <= 32'd0;
        end else if (w_drain) begin
            r_bufValid <= 1'b0;
        end else if (w_accept && bus.lng_addr != 5'd0) begin
            r_bufValid <= 1'b1;
            r_bufAddr  <= bus.lng_addr;
            r_bufData  <= bus.lng_data;
        end
    end

    // Issue is applied after drain so a same-index set/clear leaves the bit set.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_drain) begin
            w_pendingNext[r_bufAddr] = 1'b0;
        end
        if (bus.lng_issue) begin
            w_pendingNext[bus.lng_issue_addr] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pendingNext;
        end
    end

    assign bus.lng_ready      = w_lngReady;
    assign bus.pipe_hold      = ~rst & w_forceDrain;
    assign bus.wr_regwr       = ~rst & (w_drain | w_pipeWrite);
    assign bus.wr_regdst_addr = w_drain ? r_bufAddr : bus.pipe_regdst_addr;
    assign bus.wr_data        = w_drain ? r_bufData : bus.pipe_data;

    // The file still returns the old value during the drain cycle, so stalls hold until the edge.
    assign bus.id_stall = ~rst & (r_pending[bus.id_rs_addr] | r_pending[bus.id_rt_addr]
                                  | (bus.id_rd_valid & r_pending[bus.id_rd_addr]));

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Self-checking bench for gpr_wb_sched: directed scenarios plus randomized traffic
// against a queue-based reference model. Expectations follow GPR_WB_STARVE_EN.
module tb_gpr_wb_sched;

    localparam int unsigned STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    int   testsRun = 0;
    int   testsFailed = 0;

    gpr_wb_sched_if bus();

    gpr_wb_sched #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idleInputs();
        bus.pipe_regwr       = 1'b0;
        bus.pipe_regdst_addr = 5'd0;
        bus.pipe_data        = 32'd0;
        bus.lng_issue        = 1'b0;
        bus.lng_issue_addr   = 5'd0;
        bus.lng_valid        = 1'b0;
        bus.lng_addr         = 5'd0;
        bus.lng_data         = 32'd0;
        bus.id_rs_addr       = 5'd0;
        bus.id_rt_addr       = 5'd0;
        bus.id_rd_addr       = 5'd0;
        bus.id_rd_valid      = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        nextCycle();
        rst = 1'b0;
    endtask

    // Issues addr, returns its result the next cycle; exits at the start of the cycle the buffer is valid.
    task automatic loadBuffer(input logic [4:0] addr, input logic [31:0] data);
        idleInputs();
        bus.lng_issue = 1'b1;
        bus.lng_issue_addr = addr;
        nextCycle();
        idleInputs();
        bus.lng_valid = 1'b1;
        bus.lng_addr = addr;
        bus.lng_data = data;
        nextCycle();
        idleInputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        bus.pipe_regwr = 1'b1;
        bus.pipe_regdst_addr = 5'd4;
        bus.pipe_data = $urandom();
        bus.lng_valid = 1'b1;
        bus.lng_addr = 5'd6;
        bus.lng_issue = 1'b1;
        bus.lng_issue_addr = 5'd6;
        bus.id_rs_addr = 5'd6;
        nextCycle();
        #1;
        testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wr_regwr: got %0b expected 0", bus.wr_regwr); end
        testsRun++; if (bus.pipe_hold !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pipe_hold: got %0b expected 0", bus.pipe_hold); end
        testsRun++; if (bus.lng_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_lng_ready: got %0b expected 0", bus.lng_ready); end
        testsRun++; if (bus.id_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_id_stall: got %0b expected 0", bus.id_stall); end
        nextCycle();
        rst = 1'b0;
        idleInputs();
        bus.id_rs_addr = 5'd6;
        #1;
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_lng_ready: got %0b expected 1", bus.lng_ready); end
        testsRun++; if (bus.id_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset_id_stall: got %0b expected 0", bus.id_stall); end
        testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset_wr_regwr: got %0b expected 0", bus.wr_regwr); end
        nextCycle();
    endtask

    task automatic test_long_result();
        doReset();
        bus.lng_issue = 1'b1;
        bus.lng_issue_addr = 5'd5;
        bus.id_rs_addr = 5'd5;
        nextCycle();
        for (int c = 0; c < 2; c++) begin
            idleInputs();
            bus.id_rs_addr = 5'd5;
            #1;
            testsRun++; if (bus.id_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL long_wait_stall: cycle %0d got %0b expected 1", c, bus.id_stall); end
            testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL long_wait_wr: cycle %0d got %0b expected 0", c, bus.wr_regwr); end
            nextCycle();
        end
        bus.lng_valid = 1'b1;
        bus.lng_addr = 5'd5;
        bus.lng_data = 32'hDEADBEEF;
        #1;
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL long_accept_ready: got %0b expected 1", bus.lng_ready); end
        testsRun++; if (bus.id_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL long_accept_stall: got %0b expected 1", bus.id_stall); end
        nextCycle();
        idleInputs();
        bus.id_rs_addr = 5'd5;
        #1;
        testsRun++; if (bus.wr_regwr !== 1'b1) begin testsFailed++; $display("[TB] FAIL long_drain_wr: got %0b expected 1", bus.wr_regwr); end
        testsRun++; if (bus.wr_regdst_addr !== 5'd5) begin testsFailed++; $display("[TB] FAIL long_drain_addr: got %0d expected 5", bus.wr_regdst_addr); end
        testsRun++; if (bus.wr_data !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL long_drain_data: got %h expected deadbeef", bus.wr_data); end
        testsRun++; if (bus.id_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL long_drain_stall: got %0b expected 1", bus.id_stall); end
        testsRun++; if (bus.lng_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL long_drain_ready: got %0b expected 0", bus.lng_ready); end
        nextCycle();
        #1;
        testsRun++; if (bus.id_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL long_after_stall: got %0b expected 0", bus.id_stall); end
        testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL long_after_wr: got %0b expected 0", bus.wr_regwr); end
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL long_after_ready: got %0b expected 1", bus.lng_ready); end
        nextCycle();
    endtask

    task automatic test_starvation();
        logic [31:0] bufData = $urandom();
        logic [31:0] pipeData;
        doReset();
        loadBuffer(5'd7, bufData);
`ifdef GPR_WB_STARVE_EN
        for (int k = 0; k <= int'(STARVE_MAX) + 1; k++) begin
            pipeData = $urandom();
            bus.pipe_regwr = 1'b1;
            bus.pipe_regdst_addr = 5'd3;
            bus.pipe_data = pipeData;
            #1;
            if (k == int'(STARVE_MAX)) begin
                testsRun++; if (bus.wr_regdst_addr !== 5'd7 || bus.wr_data !== bufData || bus.wr_regwr !== 1'b1) begin testsFailed++; $display("[TB] FAIL starve_force_write: got en=%0b addr=%0d data=%h expected en=1 addr=7 data=%h", bus.wr_regwr, bus.wr_regdst_addr, bus.wr_data, bufData); end
                testsRun++; if (bus.pipe_hold !== 1'b1) begin testsFailed++; $display("[TB] FAIL starve_force_hold: got %0b expected 1", bus.pipe_hold); end
            end else begin
                testsRun++; if (bus.wr_regdst_addr !== 5'd3 || bus.wr_data !== pipeData || bus.wr_regwr !== 1'b1) begin testsFailed++; $display("[TB] FAIL starve_pipe_write: cycle %0d got en=%0b addr=%0d data=%h expected en=1 addr=3 data=%h", k, bus.wr_regwr, bus.wr_regdst_addr, bus.wr_data, pipeData); end
                testsRun++; if (bus.pipe_hold !== 1'b0) begin testsFailed++; $display("[TB] FAIL starve_pipe_hold: cycle %0d got %0b expected 0", k, bus.pipe_hold); end
            end
            nextCycle();
        end
        idleInputs();
        #1;
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL starve_after_ready: got %0b expected 1", bus.lng_ready); end
`else
        for (int k = 0; k < 12; k++) begin
            pipeData = $urandom();
            bus.pipe_regwr = 1'b1;
            bus.pipe_regdst_addr = 5'd3;
            bus.pipe_data = pipeData;
            #1;
            testsRun++; if (bus.wr_regdst_addr !== 5'd3 || bus.wr_data !== pipeData || bus.wr_regwr !== 1'b1) begin testsFailed++; $display("[TB] FAIL nostarve_pipe_write: cycle %0d got en=%0b addr=%0d data=%h expected en=1 addr=3 data=%h", k, bus.wr_regwr, bus.wr_regdst_addr, bus.wr_data, pipeData); end
            testsRun++; if (bus.pipe_hold !== 1'b0) begin testsFailed++; $display("[TB] FAIL nostarve_hold: cycle %0d got %0b expected 0", k, bus.pipe_hold); end
            testsRun++; if (bus.lng_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL nostarve_ready: cycle %0d got %0b expected 0", k, bus.lng_ready); end
            nextCycle();
        end
        idleInputs();
        #1;
        testsRun++; if (bus.wr_regdst_addr !== 5'd7 || bus.wr_data !== bufData || bus.wr_regwr !== 1'b1) begin testsFailed++; $display("[TB] FAIL nostarve_drain: got en=%0b addr=%0d data=%h expected en=1 addr=7 data=%h", bus.wr_regwr, bus.wr_regdst_addr, bus.wr_data, bufData); end
        nextCycle();
        #1;
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL nostarve_after_ready: got %0b expected 1", bus.lng_ready); end
`endif
        nextCycle();
    endtask

    task automatic test_r0();
        doReset();
        bus.lng_issue = 1'b1;
        bus.lng_issue_addr = 5'd0;
        bus.id_rd_valid = 1'b1;
        #1;
        testsRun++; if (bus.id_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL r0_issue_stall: got %0b expected 0", bus.id_stall); end
        nextCycle();
        idleInputs();
        bus.id_rd_valid = 1'b1;
        bus.lng_valid = 1'b1;
        bus.lng_addr = 5'd0;
        bus.lng_data = $urandom();
        #1;
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL r0_accept_ready: got %0b expected 1", bus.lng_ready); end
        testsRun++; if (bus.id_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL r0_accept_stall: got %0b expected 0", bus.id_stall); end
        nextCycle();
        idleInputs();
        bus.id_rd_valid = 1'b1;
        bus.pipe_regwr = 1'b1;
        bus.pipe_regdst_addr = 5'd0;
        bus.pipe_data = $urandom();
        #1;
        testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL r0_no_write: got %0b expected 0", bus.wr_regwr); end
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL r0_buffer_empty: got %0b expected 1", bus.lng_ready); end
        testsRun++; if (bus.id_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL r0_later_stall: got %0b expected 0", bus.id_stall); end
        nextCycle();
    endtask

    task automatic test_pipe_r0_free();
        logic [31:0] bufData = $urandom();
        doReset();
        loadBuffer(5'd9, bufData);
        bus.pipe_regwr = 1'b1;
        bus.pipe_regdst_addr = 5'd0;
        bus.pipe_data = ~bufData;
        #1;
        testsRun++; if (bus.wr_regwr !== 1'b1 || bus.wr_regdst_addr !== 5'd9 || bus.wr_data !== bufData) begin testsFailed++; $display("[TB] FAIL r0_free_drain: got en=%0b addr=%0d data=%h expected en=1 addr=9 data=%h", bus.wr_regwr, bus.wr_regdst_addr, bus.wr_data, bufData); end
        testsRun++; if (bus.pipe_hold !== 1'b0) begin testsFailed++; $display("[TB] FAIL r0_free_hold: got %0b expected 0", bus.pipe_hold); end
        nextCycle();
        idleInputs();
        #1;
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL r0_free_after_ready: got %0b expected 1", bus.lng_ready); end
        nextCycle();
    endtask

    task automatic test_reset_mid();
        doReset();
        bus.lng_issue = 1'b1;
        bus.lng_issue_addr = 5'd12;
        nextCycle();
        loadBuffer(5'd20, $urandom());
        bus.id_rs_addr = 5'd12;
        bus.id_rt_addr = 5'd20;
        #1;
        testsRun++; if (bus.id_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_before_stall: got %0b expected 1", bus.id_stall); end
        rst = 1'b1;
        #1;
        testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_wr: got %0b expected 0", bus.wr_regwr); end
        nextCycle();
        rst = 1'b0;
        #1;
        testsRun++; if (bus.id_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_stall: got %0b expected 0", bus.id_stall); end
        testsRun++; if (bus.lng_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_ready: got %0b expected 1", bus.lng_ready); end
        testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_no_drain: got %0b expected 0", bus.wr_regwr); end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] items[5];
        int offered;
        doReset();
        foreach (items[j]) items[j] = $urandom();
        for (int i = 0; i < 8; i++) begin
            offered = (i + 1) / 2;
            bus.lng_valid = 1'b1;
            bus.lng_addr = 5'(offered + 1);
            bus.lng_data = items[offered];
            #1;
            testsRun++; if (bus.lng_ready !== ((i % 2) == 0)) begin testsFailed++; $display("[TB] FAIL b2b_ready: cycle %0d got %0b expected %0b", i, bus.lng_ready, (i % 2) == 0); end
            if ((i % 2) == 1) begin
                testsRun++; if (bus.wr_regwr !== 1'b1 || bus.wr_regdst_addr !== 5'((i - 1) / 2 + 1) || bus.wr_data !== items[(i - 1) / 2]) begin testsFailed++; $display("[TB] FAIL b2b_write: cycle %0d got en=%0b addr=%0d data=%h expected en=1 addr=%0d data=%h", i, bus.wr_regwr, bus.wr_regdst_addr, bus.wr_data, (i - 1) / 2 + 1, items[(i - 1) / 2]); end
            end else begin
                testsRun++; if (bus.wr_regwr !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_idle: cycle %0d got %0b expected 0", i, bus.wr_regwr); end
            end
            nextCycle();
        end
        idleInputs();
        nextCycle();
    endtask

    task automatic test_random();
        bit          mPending[32];
        logic [4:0]  qAddr[$];
        logic [31:0] qData[$];
        int          mLost = 0;
        bit          portFree, drain, force_, expWr, expReady, expStall;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        doReset();
        foreach (mPending[j]) mPending[j] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.pipe_regwr       = ($urandom_range(0, 99) < 70);
            bus.pipe_regdst_addr = 5'($urandom_range(0, 31));
            bus.pipe_data        = $urandom();
            bus.lng_issue        = ($urandom_range(0, 99) < 30);
            bus.lng_issue_addr   = 5'($urandom_range(0, 7));
            bus.lng_valid        = ($urandom_range(0, 99) < 40);
            bus.lng_addr         = 5'($urandom_range(0, 7));
            bus.lng_data         = $urandom();
            bus.id_rs_addr       = 5'($urandom_range(0, 7));
            bus.id_rt_addr       = 5'($urandom_range(0, 7));
            bus.id_rd_addr       = 5'($urandom_range(0, 7));
            bus.id_rd_valid      = $urandom_range(0, 1);
            #1;
            portFree = !bus.pipe_regwr || bus.pipe_regdst_addr == 5'd0;
            drain = 1'b0;
            force_ = 1'b0;
            if (qAddr.size() != 0) begin
                if (portFree) drain = 1'b1;
`ifdef GPR_WB_STARVE_EN
                else if (mLost >= int'(STARVE_MAX)) begin
                    drain = 1'b1;
                    force_ = 1'b1;
                end
`endif
            end
            expWr    = drain || (bus.pipe_regwr && bus.pipe_regdst_addr != 5'd0);
            expAddr  = drain ? qAddr[0] : bus.pipe_regdst_addr;
            expData  = drain ? qData[0] : bus.pipe_data;
            expReady = (qAddr.size() == 0);
            expStall = mPending[bus.id_rs_addr] || mPending[bus.id_rt_addr] || (bus.id_rd_valid && mPending[bus.id_rd_addr]);
            testsRun++; if (bus.wr_regwr !== expWr) begin testsFailed++; $display("[TB] FAIL rand_wr_regwr: cycle %0d got %0b expected %0b", cyc, bus.wr_regwr, expWr); end
            if (expWr) begin
                testsRun++; if (bus.wr_regdst_addr !== expAddr || bus.wr_data !== expData) begin testsFailed++; $display("[TB] FAIL rand_wr_target: cycle %0d got addr=%0d data=%h expected addr=%0d data=%h", cyc, bus.wr_regdst_addr, bus.wr_data, expAddr, expData); end
            end
            testsRun++; if (bus.pipe_hold !== force_) begin testsFailed++; $display("[TB] FAIL rand_pipe_hold: cycle %0d got %0b expected %0b", cyc, bus.pipe_hold, force_); end
            testsRun++; if (bus.lng_ready !== expReady) begin testsFailed++; $display("[TB] FAIL rand_lng_ready: cycle %0d got %0b expected %0b", cyc, bus.lng_ready, expReady); end
            testsRun++; if (bus.id_stall !== expStall) begin testsFailed++; $display("[TB] FAIL rand_id_stall: cycle %0d got %0b expected %0b", cyc, bus.id_stall, expStall); end
            if (drain) begin
                mPending[qAddr[0]] = 1'b0;
                void'(qAddr.pop_front());
                void'(qData.pop_front());
                mLost = 0;
            end else if (qAddr.size() != 0) begin
                mLost++;
            end
            if (bus.lng_issue && bus.lng_issue_addr != 5'd0) mPending[bus.lng_issue_addr] = 1'b1;
            if (expReady && bus.lng_valid && bus.lng_addr != 5'd0) begin
                qAddr.push_back(bus.lng_addr);
                qData.push_back(bus.lng_data);
            end
            nextCycle();
        end
        idleInputs();
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        nextCycle();
        test_reset();
        test_long_result();
        test_starvation();
        test_r0();
        test_pipe_r0_free();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
